// File: rtl/l2_write_buffer.sv
// Coalescing write buffer between the L2 memory port and physical memory.
// Evictions are parked in a small FIFO, drained when idle, and forwarded to hitting reads.
module l2_write_buffer #(
    parameter int BLOCK_WIDTH = 256,
    parameter int ADDR_WIDTH  = 16,
    parameter int OFFSET_BITS = 5,
    parameter int DEPTH       = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [ADDR_WIDTH-1:0]  mem_address,
    input  logic                   mem_read,
    input  logic                   mem_write,
    input  logic [BLOCK_WIDTH-1:0] mem_wdata,
    output logic [BLOCK_WIDTH-1:0] mem_rdata,
    output logic                   mem_resp,
    output logic [ADDR_WIDTH-1:0]  pmem_address,
    output logic                   pmem_read,
    output logic                   pmem_write,
    output logic [BLOCK_WIDTH-1:0] pmem_wdata,
    input  logic [BLOCK_WIDTH-1:0] pmem_rdata,
    input  logic                   pmem_resp,
    output logic                   wb_empty
);
    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = IDX_W + 1;
    localparam int TAG_W = ADDR_WIDTH - OFFSET_BITS;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        READ_PMEM = 2'd1,
        DRAIN     = 2'd2,
        RESP      = 2'd3
    } state_e;

    state_e                 state_q, state_d;
    logic [CNT_W-1:0]       count_q, count_d;
    logic [IDX_W-1:0]       head_q, head_d, tail_q, tail_d;
    logic                   skip_q, skip_d;
    logic                   mem_resp_q, mem_resp_d;
    logic [BLOCK_WIDTH-1:0] mem_rdata_q, mem_rdata_d;
    logic                   pmem_read_q, pmem_read_d;
    logic                   pmem_write_q, pmem_write_d;
    logic [ADDR_WIDTH-1:0]  pmem_address_q, pmem_address_d;
    logic [BLOCK_WIDTH-1:0] pmem_wdata_q, pmem_wdata_d;
    logic                   wb_empty_q;

    logic                   valid_q [DEPTH];
    logic [TAG_W-1:0]       tag_q   [DEPTH];
    logic [BLOCK_WIDTH-1:0] data_q  [DEPTH];

    logic [TAG_W-1:0]       req_tag_s;
    logic                   hit_s;
    logic [IDX_W-1:0]       hit_idx_s;
    logic                   wr_en_s;
    logic [IDX_W-1:0]       wr_idx_s;
    logic                   inv_en_s;
    logic                   unused_offset_s;

    assign req_tag_s       = mem_address[ADDR_WIDTH-1:OFFSET_BITS];
    assign unused_offset_s = ^mem_address[OFFSET_BITS-1:0];

    // Tag lookup across all valid entries; coalescing keeps at most one match.
    always_comb begin
        hit_s     = 1'b0;
        hit_idx_s = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (valid_q[i] && (tag_q[i] == req_tag_s)) begin
                hit_s     = 1'b1;
                hit_idx_s = IDX_W'(i);
            end else begin
                hit_idx_s = hit_idx_s;
            end
        end
    end

    // Next-state and registered-output logic for the request/drain FSM.
    always_comb begin
        state_d        = state_q;
        count_d        = count_q;
        head_d         = head_q;
        tail_d         = tail_q;
        skip_d         = 1'b0;
        mem_resp_d     = 1'b0;
        mem_rdata_d    = mem_rdata_q;
        pmem_read_d    = pmem_read_q;
        pmem_write_d   = pmem_write_q;
        pmem_address_d = pmem_address_q;
        pmem_wdata_d   = pmem_wdata_q;
        wr_en_s        = 1'b0;
        wr_idx_s       = tail_q;
        inv_en_s       = 1'b0;
        case (state_q)
            IDLE: begin
                if (skip_q) begin
                    state_d = IDLE;
                end else if (mem_read) begin
                    if (hit_s) begin
                        mem_rdata_d = data_q[hit_idx_s];
                        mem_resp_d  = 1'b1;
                        state_d     = RESP;
                    end else begin
                        pmem_read_d    = 1'b1;
                        pmem_address_d = mem_address;
                        state_d        = READ_PMEM;
                    end
                end else if (mem_write && hit_s) begin
                    wr_en_s    = 1'b1;
                    wr_idx_s   = hit_idx_s;
                    mem_resp_d = 1'b1;
                    state_d    = RESP;
                end else if (mem_write && (count_q < CNT_W'(DEPTH))) begin
                    wr_en_s    = 1'b1;
                    wr_idx_s   = tail_q;
                    tail_d     = tail_q + IDX_W'(1);
                    count_d    = count_q + CNT_W'(1);
                    mem_resp_d = 1'b1;
                    state_d    = RESP;
                end else if (mem_write || (count_q != CNT_W'(0))) begin
                    // Full-buffer write and background drain both retire the head first.
                    pmem_write_d   = 1'b1;
                    pmem_address_d = {tag_q[head_q], {OFFSET_BITS{1'b0}}};
                    pmem_wdata_d   = data_q[head_q];
                    state_d        = DRAIN;
                end else begin
                    state_d = IDLE;
                end
            end
            READ_PMEM: begin
                if (pmem_resp) begin
                    pmem_read_d = 1'b0;
                    mem_rdata_d = pmem_rdata;
                    mem_resp_d  = 1'b1;
                    state_d     = RESP;
                end else begin
                    state_d = READ_PMEM;
                end
            end
            DRAIN: begin
                if (pmem_resp) begin
                    pmem_write_d = 1'b0;
                    inv_en_s     = 1'b1;
                    head_d       = head_q + IDX_W'(1);
                    count_d      = count_q - CNT_W'(1);
                    state_d      = IDLE;
                end else begin
                    state_d = DRAIN;
                end
            end
            RESP: begin
                skip_d  = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Control state and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            count_q        <= '0;
            head_q         <= '0;
            tail_q         <= '0;
            skip_q         <= 1'b0;
            mem_resp_q     <= 1'b0;
            mem_rdata_q    <= '0;
            pmem_read_q    <= 1'b0;
            pmem_write_q   <= 1'b0;
            pmem_address_q <= '0;
            pmem_wdata_q   <= '0;
            wb_empty_q     <= 1'b1;
        end else begin
            state_q        <= state_d;
            count_q        <= count_d;
            head_q         <= head_d;
            tail_q         <= tail_d;
            skip_q         <= skip_d;
            mem_resp_q     <= mem_resp_d;
            mem_rdata_q    <= mem_rdata_d;
            pmem_read_q    <= pmem_read_d;
            pmem_write_q   <= pmem_write_d;
            pmem_address_q <= pmem_address_d;
            pmem_wdata_q   <= pmem_wdata_d;
            wb_empty_q     <= (count_d == CNT_W'(0));
        end
    end

    // Entry storage: enqueue/overwrite from IDLE, invalidate head on drain completion.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                valid_q[i] <= 1'b0;
                tag_q[i]   <= '0;
                data_q[i]  <= '0;
            end
        end else begin
            if (wr_en_s) begin
                valid_q[wr_idx_s] <= 1'b1;
                tag_q[wr_idx_s]   <= req_tag_s;
                data_q[wr_idx_s]  <= mem_wdata;
            end
            if (inv_en_s) begin
                valid_q[head_q] <= 1'b0;
            end
        end
    end

    assign mem_resp     = mem_resp_q;
    assign mem_rdata    = mem_rdata_q;
    assign pmem_read    = pmem_read_q;
    assign pmem_write   = pmem_write_q;
    assign pmem_address = pmem_address_q;
    assign pmem_wdata   = pmem_wdata_q;
    assign wb_empty     = wb_empty_q;
endmodule

// File: doc/l2_write_buffer.md
Name: l2_write_buffer

Overview:
- Sits between the L2 cache's physical-memory port and physical memory, at the memory-side boundary of the processor top level.
- Absorbs dirty-block evictions from L2 into a small coalescing FIFO, so L2 miss reads reach memory without waiting behind writebacks.
- Drains buffered blocks to memory in the background whenever no read is outstanding.
- Forwards buffered data to reads that hit a pending entry.

Parameters:
- BLOCK_WIDTH, 256, bits per L2 block (mem_wdata/mem_rdata/pmem data width).
- ADDR_WIDTH, 16, byte address width.
- OFFSET_BITS, 5, block offset bits; tag = addr[ADDR_WIDTH-1:OFFSET_BITS].
- DEPTH, 4, buffer entries (power of two, >=2).

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- mem_address  in  ADDR_WIDTH  L2-side request address.
- mem_read  in  1  L2 read request, held until mem_resp.
- mem_write  in  1  L2 writeback request, held until mem_resp.
- mem_wdata  in  BLOCK_WIDTH  writeback block.
- mem_rdata  out  BLOCK_WIDTH  read data, valid while mem_resp=1.
- mem_resp  out  1  one-cycle completion pulse to L2.
- pmem_address  out  ADDR_WIDTH  physical memory address.
- pmem_read  out  1  memory read request, held until pmem_resp.
- pmem_write  out  1  memory write request, held until pmem_resp.
- pmem_wdata  out  BLOCK_WIDTH  memory write data.
- pmem_rdata  in  BLOCK_WIDTH  memory read data, valid with pmem_resp.
- pmem_resp  in  1  one-cycle memory completion.
- wb_empty  out  1  high when buffer holds zero entries.

Behaviour:
- Reset (rst_n=0, async):
  - state=IDLE, count=0, head/tail pointers=0.
  - mem_resp=0, mem_rdata=0, pmem_read=0, pmem_write=0, pmem_address=0, pmem_wdata=0, wb_empty=1.
  - Reset mid-transaction abandons the transaction immediately; no entry survives.
- Storage: DEPTH entries of {valid, tag, data}, circular FIFO with head (oldest) and tail pointers. Pointers wrap modulo DEPTH. count ranges 0..DEPTH.
- Tag match compares block tags only; offset bits are ignored. Coalescing guarantees at most one matching entry.
- All outputs are registered.
- FSM states: IDLE, READ_PMEM, DRAIN, RESP.
- IDLE, evaluated in priority order:
  1. mem_read and buffer hit: mem_rdata<=entry data; -> RESP. mem_resp is high in the cycle after the request is sampled.
  2. mem_read and miss: pmem_read<=1, pmem_address<=mem_address; -> READ_PMEM.
  3. mem_write and tag hit: overwrite that entry's data in place (count unchanged); -> RESP. Allowed even when full.
  4. mem_write, miss, count<DEPTH: enqueue at tail, count+1; -> RESP.
  5. mem_write, miss, count==DEPTH: -> DRAIN. The write stays pending and is retried in IDLE afterwards.
  6. No request and count>0: -> DRAIN (background drain).
  7. Otherwise stay in IDLE.
- mem_read and mem_write asserted together is illegal; read wins.
- READ_PMEM: hold pmem_read/pmem_address. On pmem_resp: pmem_read<=0, mem_rdata<=pmem_rdata; -> RESP.
- DRAIN:
  - On entry: pmem_write<=1, pmem_address<={head tag, OFFSET_BITS zeros}, pmem_wdata<=head data.
  - On pmem_resp: pmem_write<=0, invalidate head, head+1, count-1; -> IDLE.
  - A drain is never aborted. A read arriving mid-drain waits until the drain completes.
- RESP: mem_resp=1 for exactly one cycle; -> IDLE. The next IDLE cycle ignores the request lines for one cycle, so L2 has time to drop its held request.
- Only one pmem transaction is ever outstanding; pmem_read and pmem_write are never high together.
- wb_empty = (count==0), registered.
- Latency:
  - Buffer hit read: 2 cycles request-to-resp.
  - Write accept: 2 cycles.
  - Miss read: pmem latency + 2.

Test Plan:
- Reset with rst_n low for 3 cycles, then release: all outputs 0, wb_empty=1; no pmem activity with idle inputs.
- Write 0x1A40 with data D1, no further requests: mem_resp pulses 2 cycles later and wb_empty=0. Then DRAIN issues pmem_write, pmem_address=0x1A40, pmem_wdata=D1. After pmem_resp (model latency 5), wb_empty=1.
- Write 0x2000 (D2), then read 0x2010 before the drain starts: buffer hit; mem_rdata=D2 with mem_resp 2 cycles after the read, and no pmem_read issued.
- Write 0x3000 twice (D3 then D4), holding pmem_resp off: count stays 1; the eventual drain writes D4 once.
- Fill 4 entries (0x0000, 0x0020, 0x0040, 0x0060) with pmem_resp held off, then write 0x0080: pmem_write to 0x0000 completes first, then the 0x0080 write is accepted; count=4 at the end.
- Start a drain, assert mem_read 0x5000 (miss) mid-drain: the drain completes first, then pmem_read 0x5000 is issued; mem_rdata=pmem_rdata. Assert rst_n=0 during READ_PMEM: pmem_read drops immediately.
